// File: rtl/ldpc_ber_tester_pkg.sv
// ldpc_ber_tester_pkg: shared FSM type, default geometry and saturating add for the BER tester
package ldpc_ber_tester_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_LANE_WIDTH = 32;
  localparam int LANES = DEF_DATA_WIDTH / DEF_LANE_WIDTH;
  localparam int BEAT_ERR_W = $clog2(DEF_DATA_WIDTH + 1);
  // Adds two values of width w (<= 64), clamping to all-ones of width w instead of wrapping.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int unsigned w);
    logic [64:0] s;
    logic [64:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (65'd1 << w) - 65'd1;
    return (s > m) ? m[63:0] : s[63:0];
  endfunction
endpackage

// File: rtl/ldpc_ber_tester_popcount.sv
// ldpc_ber_tester_popcount: combinational count of ones in one lane
module ldpc_ber_tester_popcount #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]               data_i,
  output logic [$clog2(WIDTH+1)-1:0]     count_o
);
  localparam int CW = $clog2(WIDTH + 1);
  // Linear sum of bits; synthesis restructures it into a compressor tree.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) count_o = count_o + CW'(data_i[i]);
  end
endmodule

// File: rtl/ldpc_ber_tester_frame_err_counter.sv
// ldpc_ber_tester_frame_err_counter: bit/frame error accumulator on the decoder hard-decision stream
module ldpc_ber_tester_frame_err_counter
  import ldpc_ber_tester_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int LANE_WIDTH  = DEF_LANE_WIDTH,
  parameter int COUNT_WIDTH = 64,
  parameter int FRAME_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [FRAME_WIDTH-1:0] frame_limit,
  input  logic [DATA_WIDTH-1:0]  last_mask,
  input  logic [DATA_WIDTH-1:0]  s_axis_dout_tdata,
  input  logic                   s_axis_dout_tvalid,
  output logic                   s_axis_dout_tready,
  input  logic                   s_axis_dout_tlast,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] bit_errors,
  output logic [COUNT_WIDTH-1:0] frame_errors,
  output logic [COUNT_WIDTH-1:0] frames_seen,
  output logic [FRAME_WIDTH-1:0] max_frame_errors
);
  localparam int NL = DATA_WIDTH / LANE_WIDTH;
  localparam int LW = $clog2(LANE_WIDTH + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  state_t                   state_q, state_d;
  logic                     tready_q, tready_d;
  logic                     hs, clear, limit_hit, pipe_busy;
  logic [FRAME_WIDTH-1:0]   frames_acc_q, frames_acc_d;
  logic                     s0_v_q, s0_last_q;
  logic [DATA_WIDTH-1:0]    s0_data_q;
  logic [NL-1:0][LW-1:0]    lane_cnt;
  logic                     s1_v_q, s1_last_q;
  logic [NL-1:0][LW-1:0]    s1_cnt_q;
  logic [BW-1:0]            beat_sum;
  logic                     s2_v_q, s2_last_q;
  logic [BW-1:0]            s2_err_q;
  logic                     s3_v_q, s3_last_q;
  logic [BW-1:0]            s3_err_q;
  logic [COUNT_WIDTH-1:0]   bit_errors_q, bit_errors_d;
  logic [COUNT_WIDTH-1:0]   frame_errors_q, frame_errors_d;
  logic [COUNT_WIDTH-1:0]   frames_seen_q, frames_seen_d;
  logic [FRAME_WIDTH-1:0]   max_q, max_d;
  logic [FRAME_WIDTH-1:0]   frame_acc_q, frame_acc_d, frame_tot;

  // Test control: accepted-frame tally against the limit, state and registered tready.
  always_comb begin
    hs = s_axis_dout_tvalid & tready_q;
    clear = start & (state_q == IDLE || state_q == DONE);
    pipe_busy = s0_v_q | s1_v_q | s2_v_q | s3_v_q;
    frames_acc_d = clear ? '0 :
                   (hs && s_axis_dout_tlast) ? FRAME_WIDTH'(sat_add(64'(frames_acc_q), 64'd1, FRAME_WIDTH)) :
                   frames_acc_q;
    limit_hit = hs & s_axis_dout_tlast & (frame_limit != '0) & (frames_acc_d == frame_limit);
    state_d = clear ? RUN :
              (state_q == RUN && (stop || limit_hit)) ? DRAIN :
              (state_q == DRAIN && !pipe_busy) ? DONE :
              state_q;
    tready_d = (state_d == RUN);
  end

  // Control registers; reset aborts any test immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tready_q     <= 1'b0;
      frames_acc_q <= '0;
    end else begin
      state_q      <= state_d;
      tready_q     <= tready_d;
      frames_acc_q <= frames_acc_d;
    end
  end

  for (genvar l = 0; l < NL; l++) begin : g_lane
    ldpc_ber_tester_popcount #(.WIDTH(LANE_WIDTH)) u_pc (
      .data_i  (s0_data_q[l*LANE_WIDTH +: LANE_WIDTH]),
      .count_o (lane_cnt[l])
    );
  end

  // Adder tree reducing lane popcounts to the per-beat error count.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < NL; i++) beat_sum = beat_sum + BW'(s1_cnt_q[i]);
  end

  // Four-stage pipeline: capture/mask, lane popcount, sum, and a holding stage feeding the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_v_q    <= 1'b0;
      s0_last_q <= 1'b0;
      s0_data_q <= '0;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      s1_cnt_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_last_q <= 1'b0;
      s2_err_q  <= '0;
      s3_v_q    <= 1'b0;
      s3_last_q <= 1'b0;
      s3_err_q  <= '0;
    end else begin
      s0_v_q <= hs;
      if (hs) begin
        s0_data_q <= s_axis_dout_tlast ? (s_axis_dout_tdata & last_mask) : s_axis_dout_tdata;
        s0_last_q <= s_axis_dout_tlast;
      end
      s1_v_q <= s0_v_q;
      if (s0_v_q) begin
        s1_cnt_q  <= lane_cnt;
        s1_last_q <= s0_last_q;
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_err_q  <= beat_sum;
        s2_last_q <= s1_last_q;
      end
      s3_v_q <= s2_v_q;
      if (s2_v_q) begin
        s3_err_q  <= s2_err_q;
        s3_last_q <= s2_last_q;
      end
    end
  end

  // Saturating accumulation; a frame is only closed when its last beat arrives here.
  always_comb begin
    frame_tot = FRAME_WIDTH'(sat_add(64'(frame_acc_q), 64'(s3_err_q), FRAME_WIDTH));
    bit_errors_d = clear ? '0 :
                   s3_v_q ? COUNT_WIDTH'(sat_add(64'(bit_errors_q), 64'(s3_err_q), COUNT_WIDTH)) :
                   bit_errors_q;
    frame_acc_d = clear ? '0 : s3_v_q ? (s3_last_q ? '0 : frame_tot) : frame_acc_q;
    frames_seen_d = clear ? '0 :
                    (s3_v_q && s3_last_q) ? COUNT_WIDTH'(sat_add(64'(frames_seen_q), 64'd1, COUNT_WIDTH)) :
                    frames_seen_q;
    frame_errors_d = clear ? '0 :
                     (s3_v_q && s3_last_q && frame_tot != '0) ?
                       COUNT_WIDTH'(sat_add(64'(frame_errors_q), 64'd1, COUNT_WIDTH)) :
                     frame_errors_q;
    max_d = clear ? '0 : (s3_v_q && s3_last_q && frame_tot > max_q) ? frame_tot : max_q;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_errors_q   <= '0;
      frame_errors_q <= '0;
      frames_seen_q  <= '0;
      max_q          <= '0;
      frame_acc_q    <= '0;
    end else begin
      bit_errors_q   <= bit_errors_d;
      frame_errors_q <= frame_errors_d;
      frames_seen_q  <= frames_seen_d;
      max_q          <= max_d;
      frame_acc_q    <= frame_acc_d;
    end
  end

  assign s_axis_dout_tready = tready_q;
  assign busy               = (state_q == RUN) || (state_q == DRAIN);
  assign done               = (state_q == DONE);
  assign bit_errors         = bit_errors_q;
  assign frame_errors       = frame_errors_q;
  assign frames_seen        = frames_seen_q;
  assign max_frame_errors   = max_q;
endmodule
